// File: rtl/byte_packer_wr.sv
// ---------------------------------------------------------------------------
// byte_packer_wr
//
// Packs a stream of byte writes into 32-bit word writes with per-lane byte
// enables. Bytes that land in the same word are merged in a one-word buffer.
// The buffered word is issued when all four lanes are filled, when a byte
// for a different word arrives, or on flush.
//
// Optional feature: define BYTE_PACKER_TIMEOUT_EN to auto-flush a partial
// word after TIMEOUT_CYCLES idle cycles in FILL.
//
// Ports:
//   clk, rst_n       - clock (rising edge), asynchronous active-low reset
//   byte_wr_valid    - byte write request
//   byte_wr_ready    - byte accepted when valid && ready (combinational)
//   byte_addr_in     - byte address
//   byte_data_in     - byte data
//   flush            - force out any partial word
//   word_wr_valid    - word write pending (registered)
//   word_wr_ready    - memory accepts the word write
//   word_addr_out    - word address (byte_addr[W-1:2])
//   word_data_out    - packed word, unwritten lanes read as 0
//   word_be_out      - lane enables, bit k covers data[8k+7:8k]
//   busy             - state is not IDLE
// ---------------------------------------------------------------------------
module byte_packer_wr #(
    parameter int BYTE_ADDR_WIDTH = 6,
    parameter int TIMEOUT_CYCLES  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       byte_wr_valid,
    output logic                       byte_wr_ready,
    input  logic [BYTE_ADDR_WIDTH-1:0] byte_addr_in,
    input  logic [7:0]                 byte_data_in,
    input  logic                       flush,
    output logic                       word_wr_valid,
    input  logic                       word_wr_ready,
    output logic [BYTE_ADDR_WIDTH-3:0] word_addr_out,
    output logic [31:0]                word_data_out,
    output logic [3:0]                 word_be_out,
    output logic                       busy
);

    localparam int WAW = BYTE_ADDR_WIDTH - 2;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("byte_packer_wr: TIMEOUT_CYCLES must be in 1..255");
    end
    if (BYTE_ADDR_WIDTH < 3) begin : g_bad_width
        $error("byte_packer_wr: BYTE_ADDR_WIDTH must be at least 3");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [WAW-1:0]  addr_q, addr_d;
    logic [31:0]     data_q, data_d;
    logic [3:0]      be_q, be_d;
    logic            valid_q, valid_d;

    logic [WAW-1:0]  in_waddr;
    logic [1:0]      in_lane;
    logic            same_word;
    logic            accept;
    logic [3:0]      lane_be;
    logic [3:0]      be_merged;
    logic [31:0]     ins_base;
    logic [31:0]     data_merged;
    logic            tmo_hit;

    assign in_waddr  = byte_addr_in[BYTE_ADDR_WIDTH-1:2];
    assign in_lane   = byte_addr_in[1:0];
    assign same_word = (in_waddr == addr_q);
    assign accept    = byte_wr_valid && byte_wr_ready;
    assign lane_be   = 4'b0001 << in_lane;
    assign be_merged = be_q | lane_be;

    // A fresh word starts from zero so unwritten lanes always read as 0.
    assign ins_base  = (state_q == IDLE) ? 32'd0 : data_q;

    always_comb begin
        data_merged = ins_base;
        case (in_lane)
            2'd0:    data_merged[7:0]   = byte_data_in;
            2'd1:    data_merged[15:8]  = byte_data_in;
            2'd2:    data_merged[23:16] = byte_data_in;
            default: data_merged[31:24] = byte_data_in;
        endcase
    end

`ifdef BYTE_PACKER_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt_q, tmo_cnt_d;

    // Counter holds the number of idle FILL cycles already seen; the cycle
    // in which it equals TIMEOUT_CYCLES-1 is the last tolerated idle cycle.
    assign tmo_hit = (state_q == FILL) && !accept && (tmo_cnt_q == TMO_LAST);

    always_comb begin
        tmo_cnt_d = 8'd0;
        if (state_d == FILL && state_q == FILL && !accept)
            tmo_cnt_d = tmo_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_cnt_q <= 8'd0;
        else        tmo_cnt_q <= tmo_cnt_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // State register and buffer/output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= 32'd0;
            be_q    <= 4'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            be_q    <= be_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = flush ? WRITE : FILL;
            end
            FILL: begin
                if (accept) begin
                    if (be_merged == 4'b1111 || flush) state_d = WRITE;
                end else if (byte_wr_valid) begin
                    // Byte for another word: push out the current buffer;
                    // the byte is taken from IDLE afterwards.
                    state_d = WRITE;
                end else if (flush || tmo_hit) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (word_wr_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath logic.
    always_comb begin
        byte_wr_ready = 1'b0;
        addr_d        = addr_q;
        data_d        = data_q;
        be_d          = be_q;
        case (state_q)
            IDLE: begin
                byte_wr_ready = 1'b1;
                if (accept) begin
                    addr_d = in_waddr;
                    data_d = data_merged;
                    be_d   = lane_be;
                end
            end
            FILL: begin
                byte_wr_ready = !(byte_wr_valid && !same_word);
                if (accept) begin
                    data_d = data_merged;
                    be_d   = be_merged;
                end
            end
            WRITE: begin
                if (word_wr_ready) begin
                    data_d = 32'd0;
                    be_d   = 4'd0;
                end
            end
            default: ;
        endcase
        valid_d = (state_d == WRITE);
    end

    assign word_wr_valid = valid_q;
    assign word_addr_out = addr_q;
    assign word_data_out = data_q;
    assign word_be_out   = be_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_byte_packer_wr.sv
module tb_byte_packer_wr;

    logic        clk;
    logic        rst_n;
    logic        byte_wr_valid;
    logic        byte_wr_ready;
    logic [5:0]  byte_addr_in;
    logic [7:0]  byte_data_in;
    logic        flush;
    logic        word_wr_valid;
    logic        word_wr_ready;
    logic [3:0]  word_addr_out;
    logic [31:0] word_data_out;
    logic [3:0]  word_be_out;
    logic        busy;

    int checks;
    int failures;

    byte_packer_wr #(.BYTE_ADDR_WIDTH(6), .TIMEOUT_CYCLES(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .byte_wr_valid (byte_wr_valid),
        .byte_wr_ready (byte_wr_ready),
        .byte_addr_in  (byte_addr_in),
        .byte_data_in  (byte_data_in),
        .flush         (flush),
        .word_wr_valid (word_wr_valid),
        .word_wr_ready (word_wr_ready),
        .word_addr_out (word_addr_out),
        .word_data_out (word_data_out),
        .word_be_out   (word_be_out),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bw(input logic [5:0] a, input logic [7:0] d);
        byte_wr_valid = 1'b1;
        byte_addr_in  = a;
        byte_data_in  = d;
    endtask

    int          seen_at;
    logic [31:0] cap_data;
    logic [3:0]  cap_be;

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; byte_wr_valid = 1'b0; byte_addr_in = '0; byte_data_in = '0;
        flush = 1'b0; word_wr_ready = 1'b0;
        #3;
        chk("rst_valid", 32'(word_wr_valid), 32'd0);
        chk("rst_addr",  32'(word_addr_out), 32'd0);
        chk("rst_data",  word_data_out,      32'd0);
        chk("rst_be",    32'(word_be_out),   32'd0);
        chk("rst_busy",  32'(busy),          32'd0);
        chk("rst_ready", 32'(byte_wr_ready), 32'd1);
        @(negedge clk); rst_n = 1'b1;
        tick();

        // Full word, consecutive bytes.
        word_wr_ready = 1'b1;
        bw(6'd4, 8'h11); tick();
        bw(6'd5, 8'h22); tick();
        bw(6'd6, 8'h33); tick();
        chk("t1_valid_early", 32'(word_wr_valid), 32'd0);
        bw(6'd7, 8'h44); tick();
        byte_wr_valid = 1'b0; #1;
        chk("t1_valid", 32'(word_wr_valid), 32'd1);
        chk("t1_addr",  32'(word_addr_out), 32'd1);
        chk("t1_data",  word_data_out,      32'h44332211);
        chk("t1_be",    32'(word_be_out),   32'hF);
        chk("t1_busy",  32'(busy),          32'd1);
        chk("t1_rdy",   32'(byte_wr_ready), 32'd0);
        tick();
        chk("t1_done_valid", 32'(word_wr_valid), 32'd0);
        chk("t1_done_be",    32'(word_be_out),   32'd0);
        chk("t1_done_data",  word_data_out,      32'd0);
        chk("t1_done_busy",  32'(busy),          32'd0);

        // Word change.
        bw(6'd8, 8'hAA); tick();
        bw(6'd12, 8'hBB); #1;
        chk("t2_rdy_fill", 32'(byte_wr_ready), 32'd0);
        tick();
        chk("t2_valid", 32'(word_wr_valid), 32'd1);
        chk("t2_addr",  32'(word_addr_out), 32'd2);
        chk("t2_data",  word_data_out,      32'h000000AA);
        chk("t2_be",    32'(word_be_out),   32'h1);
        chk("t2_rdy_wr", 32'(byte_wr_ready), 32'd0);
        tick();
        chk("t2_idle_valid", 32'(word_wr_valid), 32'd0);
        chk("t2_idle_rdy",   32'(byte_wr_ready), 32'd1);
        tick();
        byte_wr_valid = 1'b0; #1;
        chk("t2_bb_busy", 32'(busy),          32'd1);
        chk("t2_bb_be",   32'(word_be_out),   32'h1);
        chk("t2_bb_data", word_data_out,      32'h000000BB);
        chk("t2_bb_addr", 32'(word_addr_out), 32'd3);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("t2_fl_valid", 32'(word_wr_valid), 32'd1);
        chk("t2_fl_data",  word_data_out,      32'h000000BB);
        tick();
        chk("t2_fl_done", 32'(word_wr_valid), 32'd0);

        // Backpressure during WRITE.
        word_wr_ready = 1'b0;
        bw(6'd17, 8'h77); flush = 1'b1; tick(); flush = 1'b0;
        bw(6'd20, 8'h55); #1;
        chk("t3_valid", 32'(word_wr_valid), 32'd1);
        chk("t3_data",  word_data_out,      32'h00007700);
        chk("t3_be",    32'(word_be_out),   32'h2);
        chk("t3_addr",  32'(word_addr_out), 32'd4);
        chk("t3_rdy",   32'(byte_wr_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_hold_valid", 32'(word_wr_valid), 32'd1);
            chk("t3_hold_data",  word_data_out,      32'h00007700);
            chk("t3_hold_rdy",   32'(byte_wr_ready), 32'd0);
        end
        byte_wr_valid = 1'b0; word_wr_ready = 1'b1;
        tick();
        chk("t3_rel_valid", 32'(word_wr_valid), 32'd0);
        chk("t3_rel_busy",  32'(busy),          32'd0);

        // Overwrite then flush; flush in IDLE is a no-op.
        bw(6'd2, 8'h01); tick();
        chk("t4_d1",  word_data_out,    32'h00010000);
        chk("t4_be1", 32'(word_be_out), 32'h4);
        bw(6'd2, 8'h02); tick();
        byte_wr_valid = 1'b0; #1;
        chk("t4_d2",  word_data_out,      32'h00020000);
        chk("t4_be2", 32'(word_be_out),   32'h4);
        chk("t4_v2",  32'(word_wr_valid), 32'd0);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("t4_valid", 32'(word_wr_valid), 32'd1);
        chk("t4_data",  word_data_out,      32'h00020000);
        chk("t4_be",    32'(word_be_out),   32'h4);
        chk("t4_addr",  32'(word_addr_out), 32'd0);
        tick();
        chk("t4_done", 32'(word_wr_valid), 32'd0);
        flush = 1'b1; tick();
        chk("t4_idle_fl_valid", 32'(word_wr_valid), 32'd0);
        chk("t4_idle_fl_busy",  32'(busy),          32'd0);
        tick(); flush = 1'b0;
        chk("t4_idle_fl_valid2", 32'(word_wr_valid), 32'd0);

        // Reset while a word is pending.
        word_wr_ready = 1'b0;
        bw(6'd40, 8'h99); flush = 1'b1; tick();
        byte_wr_valid = 1'b0; flush = 1'b0; #1;
        chk("t5_valid", 32'(word_wr_valid), 32'd1);
        chk("t5_addr",  32'(word_addr_out), 32'd10);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(word_wr_valid), 32'd0);
        chk("t5_rst_addr",  32'(word_addr_out), 32'd0);
        chk("t5_rst_data",  word_data_out,      32'd0);
        chk("t5_rst_be",    32'(word_be_out),   32'd0);
        chk("t5_rst_busy",  32'(busy),          32'd0);
        chk("t5_rst_rdy",   32'(byte_wr_ready), 32'd1);
        @(negedge clk); rst_n = 1'b1; word_wr_ready = 1'b1;
        tick(); tick();
        chk("t5_after_valid", 32'(word_wr_valid), 32'd0);
        chk("t5_after_busy",  32'(busy),          32'd0);

        // Idle partial word: auto-flush only with the timeout feature.
        bw(6'd0, 8'h5A); tick();
        byte_wr_valid = 1'b0;
        seen_at = 0; cap_data = 32'd0; cap_be = 4'd0;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (word_wr_valid && seen_at == 0) begin
                seen_at  = i;
                cap_data = word_data_out;
                cap_be   = word_be_out;
            end
        end
`ifdef BYTE_PACKER_TIMEOUT_EN
        chk("t6_tmo_cycle", 32'(seen_at), 32'd8);
`else
        chk("t6_no_tmo", 32'(seen_at), 32'd0);
`endif
        if (seen_at == 0) begin
            flush = 1'b1; tick(); flush = 1'b0;
            cap_data = word_data_out;
            cap_be   = word_be_out;
        end
        chk("t6_data", cap_data,     32'h0000005A);
        chk("t6_be",   32'(cap_be),  32'h1);
        tick();
        chk("t6_done", 32'(word_wr_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
